// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pll_seq_pkg                                                  |
// | Description : Shared types and constants for the PLL lock sequencer:       |
// |               state encoding, status field widths, loss counter ceiling    |
// |               and a counter-width helper.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pll_seq_pkg;

  localparam int STATE_W      = 3;
  localparam int RETRY_W      = 2;
  localparam int LOSS_W       = 8;
  localparam int LOSS_CNT_MAX = 255;

  // Encoding is visible on the state port, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : Two-flop synchronizer for one asynchronous level signal.     |
// | Ports       : clk - destination clock                                      |
// |               rst - synchronous active-high reset (both flops clear to 0)  |
// |               d   - asynchronous input                                     |
// |               q   - synchronized output, two clk cycles behind d           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_lock_sequencer                                           |
// | Description : Drives the PLL through reset, lock acquisition and lock      |
// |               qualification; holds the downstream system reset until the   |
// |               lock has been continuously stable; re-sequences on loss of   |
// |               lock and latches a fault after repeated lock timeouts.       |
// | Ports       : refclk     - reference clock (only clock)                    |
// |               rst        - synchronous active-high reset                   |
// |               pll_locked - PLL lock indication, asynchronous               |
// |               restart    - one-cycle request to re-run the sequence        |
// |               pll_rst    - PLL reset, active high                          |
// |               sys_rst    - downstream system reset, active high            |
// |               ready      - high only in RUN                                |
// |               fault      - high only in FAULT                              |
// |               state      - encoded current state                           |
// |               retry_cnt  - lock timeouts in the current acquisition        |
// |               loss_cnt   - loss-of-lock events in RUN, saturating          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam int PHASE_W  = cnt_width(RST_CYCLES);
  localparam int TIMER_W  = cnt_width(LOCK_TIMEOUT);
  localparam int STABLE_W = cnt_width(STABLE_CYCLES);

  localparam logic [PHASE_W-1:0]  PHASE_LAST  = PHASE_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]   LOSS_SAT    = LOSS_W'(LOSS_CNT_MAX);

  seq_state_t          cur_state;
  seq_state_t          nxt_state;
  logic                lk;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [TIMER_W-1:0]  lock_timer;
  logic [TIMER_W-1:0]  timer_nxt;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_nxt;
  logic [RETRY_W-1:0]  retry_nxt;
  logic [RETRY_W-1:0]  retry_inc;
  logic [LOSS_W-1:0]   loss_nxt;
  logic                timeout;
  logic                pll_rst_nxt;
  logic                sys_rst_nxt;
  logic                ready_nxt;
  logic                fault_nxt;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign timeout   = (lock_timer == TIMER_LAST);
  assign retry_inc = retry_cnt + RETRY_W'(1);
  assign state     = cur_state;

  // --------------------------------------------------------------------------
  // State, counters and output registers. Outputs are decoded from the next
  // state so they move on the same edge as the state itself; on rst the two
  // resets load high directly, so they cannot dip low on the way in.
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state  <= ST_RESET_PLL;
      phase_cnt  <= '0;
      lock_timer <= '0;
      stable_cnt <= '0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      phase_cnt  <= phase_nxt;
      lock_timer <= timer_nxt;
      stable_cnt <= stable_nxt;
      retry_cnt  <= retry_nxt;
      loss_cnt   <= loss_nxt;
      pll_rst    <= pll_rst_nxt;
      sys_rst    <= sys_rst_nxt;
      ready      <= ready_nxt;
      fault      <= fault_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and counter updates. Every counter defaults to zero and only
  // advances inside the state that owns it, so leaving a state clears it.
  // --------------------------------------------------------------------------
  always_comb begin
    nxt_state  = cur_state;
    phase_nxt  = '0;
    timer_nxt  = '0;
    stable_nxt = '0;
    retry_nxt  = retry_cnt;
    loss_nxt   = loss_cnt;

    if (restart) begin
      nxt_state = ST_RESET_PLL;
      retry_nxt = '0;
    end else begin
      unique case (cur_state)
        ST_RESET_PLL: begin
          if (phase_cnt == PHASE_LAST) begin
            nxt_state = ST_WAIT_LOCK;
          end else begin
            phase_nxt = phase_cnt + PHASE_W'(1);
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          // The acquisition window spans both states and wins over any
          // lock progress seen on the same cycle.
          if (timeout) begin
            retry_nxt = retry_inc;
            nxt_state = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
          end else begin
            timer_nxt = lock_timer + TIMER_W'(1);
            if (cur_state == ST_WAIT_LOCK) begin
              if (lk) begin
                nxt_state = ST_STABLE;
              end
            end else if (!lk) begin
              // A dropout during qualification only restarts qualification.
              nxt_state = ST_WAIT_LOCK;
            end else if (stable_cnt == STABLE_LAST) begin
              nxt_state = ST_RUN;
              retry_nxt = '0;
            end else begin
              stable_nxt = stable_cnt + STABLE_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (!lk) begin
            nxt_state = ST_RESET_PLL;
            if (loss_cnt != LOSS_SAT) begin
              loss_nxt = loss_cnt + LOSS_W'(1);
            end
          end
        end

        ST_FAULT: begin
          nxt_state = ST_FAULT;
        end

        default: begin
          nxt_state = ST_RESET_PLL;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state.
  // --------------------------------------------------------------------------
  always_comb begin
    pll_rst_nxt = 1'b1;
    sys_rst_nxt = 1'b1;
    ready_nxt   = 1'b0;
    fault_nxt   = 1'b0;
    unique case (nxt_state)
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_rst_nxt = 1'b0;
      end
      ST_RUN: begin
        pll_rst_nxt = 1'b0;
        sys_rst_nxt = 1'b0;
        ready_nxt   = 1'b1;
      end
      ST_FAULT: begin
        fault_nxt = 1'b1;
      end
      default: begin
        pll_rst_nxt = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_lock_sequencer                                        |
// | Description : Self-checking bench for pll_lock_sequencer. A cycle-level   |
// |               behavioural model (elapsed-cycle bookkeeping) predicts the   |
// |               full status vector every cycle; directed scenarios check     |
// |               sequence timing, timeout-to-fault, restart, loss-of-lock     |
// |               saturation and mid-sequence reset. Timing parameters are     |
// |               scaled down to keep run time short.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_lock_sequencer;

  localparam int RC = 16;
  localparam int LT = 600;
  localparam int SC = 64;
  localparam int MR = 3;

  localparam int M_RESET  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .state     (state),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode    = M_RESET;
  int m_held    = 0;   // cycles spent holding the PLL in reset this attempt
  int m_elapsed = 0;   // cycles since PLL reset release this attempt
  int m_streak  = 0;   // consecutive locked cycles seen during qualification
  int m_retries = 0;
  int m_losses  = 0;
  bit m_s1      = 1'b0;
  bit m_s2      = 1'b0;

  task automatic model_step(input logic r, input logic rs, input logic pl);
    bit lk;
    lk = m_s2;
    if (r) begin
      m_mode = M_RESET; m_held = 0; m_elapsed = 0; m_streak = 0;
      m_retries = 0; m_losses = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pl;
    if (rs) begin
      m_mode = M_RESET; m_held = 0; m_elapsed = 0; m_streak = 0; m_retries = 0;
      return;
    end
    case (m_mode)
      M_RESET: begin
        m_held++;
        if (m_held == RC) begin
          m_mode = M_WAIT; m_held = 0; m_elapsed = 0;
        end
      end
      M_WAIT, M_STABLE: begin
        m_elapsed++;
        if (m_elapsed == LT) begin
          m_retries++;
          m_mode = (m_retries == MR) ? M_FAULT : M_RESET;
          m_held = 0;
        end else if (m_mode == M_WAIT) begin
          if (lk) begin m_mode = M_STABLE; m_streak = 0; end
        end else if (!lk) begin
          m_mode = M_WAIT;
        end else begin
          m_streak++;
          if (m_streak == SC) begin m_mode = M_RUN; m_retries = 0; end
        end
      end
      M_RUN: begin
        if (!lk) begin
          m_mode = M_RESET; m_held = 0;
          if (m_losses < 255) m_losses++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [16:0] model_vec();
    logic pr, sr, rd, ft;
    pr = (m_mode == M_RESET) || (m_mode == M_FAULT);
    sr = (m_mode != M_RUN);
    rd = (m_mode == M_RUN);
    ft = (m_mode == M_FAULT);
    return {3'(m_mode), pr, sr, rd, ft, 2'(m_retries), 8'(m_losses)};
  endfunction

  always @(posedge refclk) begin
    cyc++;
    #1;
    model_step(rst, restart, pll_locked);
    check("cycle_status",
          32'({state, pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt}),
          32'(model_vec()));
  end

  // ---------------- bounded waits ----------------
  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag,
                            output int t);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin
      @(negedge refclk);
      n++;
    end
    t = cyc;
    check(tag, 32'(state), 32'(tgt));
  endtask

  task automatic wait_pllrst(input logic v, input int budget, input string tag,
                             output int t);
    int n;
    n = 0;
    while (pll_rst !== v && n < budget) begin
      @(negedge refclk);
      n++;
    end
    t = cyc;
    check(tag, 32'(pll_rst), 32'(v));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, t2, ta, tb, nd;
    int saved_loss;

    // Reset state
    repeat (4) @(negedge refclk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({pll_rst, sys_rst, ready, fault}), 32'b1100);
    check("rst_cnts", 32'({retry_cnt, loss_cnt}), 32'd0);

    // 1. Normal lock
    rst = 1'b0;
    t0 = cyc;
    wait_pllrst(1'b0, RC + 10, "t1_pll_rst_fall", t1);
    check("t1_pll_rst_len", 32'(t1 - t0), 32'(RC));
    repeat (99) @(negedge refclk);
    pll_locked = 1'b1;
    wait_state(3'd3, 200 + SC, "t1_reach_run", t2);
    check("t1_run_latency", 32'(t2 - t1), 32'(100 + 2 + SC));
    check("t1_sys_rst_low", 32'({sys_rst, ready}), 32'b01);
    check("t1_retry", 32'(retry_cnt), 32'd0);

    // 2. Lock chatter during qualification
    pulse_restart();
    check("t2_restart_state", 32'(state), 32'd0);
    wait_state(3'd2, RC + 20, "t2_stable", t0);
    repeat (30) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    wait_state(3'd1, 10, "t2_back_to_wait", t0);
    wait_state(3'd2, 10, "t2_restable", t1);
    wait_state(3'd3, SC + 10, "t2_run", t2);
    check("t2_run_after_relock", 32'(t2 - t1), 32'(SC));
    check("t2_retry", 32'(retry_cnt), 32'd0);

    // 3. Timeout to fault (loses lock from RUN first)
    pll_locked = 1'b0;
    wait_state(3'd0, 10, "t3_loss_to_reset", tb);
    for (int i = 0; i < MR; i++) begin
      wait_pllrst(1'b0, RC + 10, "t3_release", ta);
      check("t3_pulse_len", 32'(ta - tb), 32'(RC));
      wait_pllrst(1'b1, LT + 10, "t3_timeout", tb);
      check("t3_wait_len", 32'(tb - ta), 32'(LT));
    end
    check("t3_fault_state", 32'(state), 32'd4);
    check("t3_fault_outs", 32'({fault, pll_rst, sys_rst, ready}), 32'b1110);
    check("t3_retry", 32'(retry_cnt), 32'(MR));
    pll_locked = 1'b1;
    repeat (10) @(negedge refclk);
    check("t3_fault_sticky", 32'(state), 32'd4);

    // 4. Restart from fault
    saved_loss = int'(loss_cnt);
    pulse_restart();
    check("t4_state", 32'(state), 32'd0);
    check("t4_fault_retry", 32'({fault, retry_cnt}), 32'd0);
    wait_state(3'd3, RC + SC + 20, "t4_run", t0);
    check("t4_loss_kept", 32'(loss_cnt), 32'(saved_loss));

    // 5. Loss of lock in RUN
    saved_loss = int'(loss_cnt);
    pll_locked = 1'b0;
    nd = 0;
    while (ready === 1'b1 && nd < 6) begin
      @(negedge refclk);
      nd++;
    end
    // Sampled on the first edge, seen by the FSM two edges later.
    check("t5_loss_latency", 32'(nd), 32'd3);
    check("t5_outs", 32'({sys_rst, ready, pll_rst}), 32'b101);
    check("t5_loss_inc", 32'(loss_cnt), 32'(saved_loss + 1));
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge refclk);
      pll_locked = 1'b1;
      wait_state(3'd3, RC + SC + 40, "t5_relock", t0);
      repeat ($urandom_range(0, 6)) @(negedge refclk);
      pll_locked = 1'b0;
      wait_state(3'd0, 6, "t5_drop", t0);
    end
    check("t5_loss_sat", 32'(loss_cnt), 32'd255);

    // Random soak against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge refclk);
      if (pll_locked) begin
        if ($urandom_range(0, 149) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        pll_locked = 1'b1;
      end
      restart = ($urandom_range(0, 299) == 0);
    end
    restart = 1'b0;

    // 6. Reset mid-qualification
    pll_locked = 1'b1;
    pulse_restart();
    wait_state(3'd2, RC + 20, "t6_stable", t0);
    repeat (40) @(negedge refclk);
    check("t6_pre_outs", 32'({pll_rst, sys_rst}), 32'b01);
    rst = 1'b1;
    @(negedge refclk);
    check("t6_state", 32'(state), 32'd0);
    check("t6_cnts", 32'({retry_cnt, loss_cnt}), 32'd0);
    check("t6_outs", 32'({pll_rst, sys_rst, ready, fault}), 32'b1100);
    repeat (2) @(negedge refclk);
    check("t6_hold_outs", 32'({pll_rst, sys_rst}), 32'b11);
    rst = 1'b0;
    wait_state(3'd3, RC + SC + 20, "t6_rerun", t0);

    repeat (3) @(negedge refclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
